// File: rtl/alu32_pkg.sv
// Shared opcodes, flag indices and sequencer state
// encoding for the alu32 command sequencer.
package alu32_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_ASR  = 4'd4;
  localparam logic [3:0] OP_LSL  = 4'd5;
  localparam logic [3:0] OP_LSR  = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_NOT  = 4'd10;
  localparam logic [3:0] OP_COMP = 4'd11;
  localparam logic [3:0] OP_MAX  = 4'd11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } seq_state_t;

  function automatic logic op_illegal(
    input logic [3:0]  op,
    input logic [31:0] b
  );
    return (op > OP_MAX) ||
           ((op == OP_DIV) && (b == '0));
  endfunction

  function automatic logic op_muldiv(
    input logic [3:0] op
  );
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with first-word
// fall-through head and occupancy output.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array, written at the tail.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally; level tracks push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/alu32_cmd_seq.sv
// Issues queued ALU commands one at a time to alu32
// and returns tagged responses in command order.
module alu32_cmd_seq
  import alu32_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int TAG_W      = 4,
  parameter int ALU_LAT    = 1,
  parameter int MULDIV_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd_op,
  input  logic [31:0]            cmd_a,
  input  logic [31:0]            cmd_b,
  input  logic [TAG_W-1:0]       cmd_tag,
  output logic [31:0]            alu_a,
  output logic [31:0]            alu_b,
  output logic [3:0]             alu_op,
  input  logic [31:0]            alu_result,
  input  logic [31:0]            alu_mul_hi,
  input  logic                   alu_n,
  input  logic                   alu_z,
  input  logic                   alu_v,
  input  logic                   alu_c,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_result,
  output logic [31:0]            rsp_hi,
  output logic [3:0]             rsp_flags,
  output logic [TAG_W-1:0]       rsp_tag,
  output logic                   rsp_err,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int FW = TAG_W + 68;
  localparam int MAX_LAT =
    (ALU_LAT > MULDIV_LAT) ? ALU_LAT : MULDIV_LAT;
  localparam int CW = $clog2(MAX_LAT) + 1;
  localparam logic [CW-1:0] CNT_ALU =
    CW'(ALU_LAT - 1);
  localparam logic [CW-1:0] CNT_MD =
    CW'(MULDIV_LAT - 1);

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic [FW-1:0]    head;
  logic [TAG_W-1:0] head_tag;
  logic [3:0]       head_op;
  logic [31:0]      head_a;
  logic [31:0]      head_b;
  logic             head_bad;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             do_issue;
  logic             do_err;
  logic             do_cap;
  logic             do_dec;
  logic [CW-1:0]    cnt;
  logic [3:0]       cap_flags;

  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign {head_tag, head_op, head_a, head_b} = head;
  assign head_bad  = op_illegal(head_op, head_b);
  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE) || !fifo_empty;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({cmd_tag, cmd_op, cmd_a, cmd_b}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Pack alu32 flags into the response ordering.
  always_comb begin
    cap_flags         = '0;
    cap_flags[FLAG_N] = alu_n;
    cap_flags[FLAG_Z] = alu_z;
    cap_flags[FLAG_V] = alu_v;
    cap_flags[FLAG_C] = alu_c;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next state and per-edge datapath controls.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    do_issue  = 1'b0;
    do_err    = 1'b0;
    do_cap    = 1'b0;
    do_dec    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_bad) begin
            do_err    = 1'b1;
            state_nxt = S_RESP;
          end else begin
            do_issue  = 1'b1;
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          do_cap    = 1'b1;
          state_nxt = S_RESP;
        end else begin
          do_dec = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand, wait counter and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= OP_ADD;
      cnt        <= '0;
      rsp_result <= '0;
      rsp_hi     <= '0;
      rsp_flags  <= '0;
      rsp_tag    <= '0;
      rsp_err    <= 1'b0;
    end else begin
      unique case (1'b1)
        do_err: begin
          rsp_result <= '0;
          rsp_hi     <= '0;
          rsp_flags  <= '0;
          rsp_tag    <= head_tag;
          rsp_err    <= 1'b1;
        end
        do_issue: begin
          alu_a   <= head_a;
          alu_b   <= head_b;
          alu_op  <= head_op;
          rsp_tag <= head_tag;
          cnt     <= op_muldiv(head_op) ?
                     CNT_MD : CNT_ALU;
        end
        do_cap: begin
          rsp_result <= alu_result;
          rsp_flags  <= cap_flags;
          rsp_hi     <= (alu_op == OP_MUL) ?
                        alu_mul_hi : '0;
          rsp_err    <= 1'b0;
        end
        do_dec: cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu32_cmd_seq.sv
// Directed bench for alu32_cmd_seq with a small
// behavioural alu32 driving the result inputs.
module tb_alu32_cmd_seq;
  import alu32_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [31:0] cmd_a = '0;
  logic [31:0] cmd_b = '0;
  logic [3:0]  cmd_tag = '0;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic [31:0] alu_mul_hi;
  logic        alu_n;
  logic        alu_z;
  logic        alu_v;
  logic        alu_c;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic [31:0] rsp_hi;
  logic [3:0]  rsp_flags;
  logic [3:0]  rsp_tag;
  logic        rsp_err;
  logic        busy;
  logic [2:0]  fifo_level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu32_cmd_seq #(
    .DEPTH(4), .TAG_W(4),
    .ALU_LAT(1), .MULDIV_LAT(2)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a),
    .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_mul_hi(alu_mul_hi),
    .alu_n(alu_n), .alu_z(alu_z),
    .alu_v(alu_v), .alu_c(alu_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_hi(rsp_hi),
    .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
    .rsp_err(rsp_err), .busy(busy),
    .fifo_level(fifo_level)
  );

  // Behavioural alu32; mul_hi is driven for every op.
  logic [63:0] prod;
  logic [32:0] sum;
  always_comb begin
    prod  = 64'(alu_a) * 64'(alu_b);
    sum   = {1'b0, alu_a} + {1'b0, alu_b};
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (alu_op)
      OP_ADD: begin
        alu_result = sum[31:0];
        alu_c = sum[32];
        alu_v = (alu_a[31] == alu_b[31]) &&
                (sum[31] != alu_a[31]);
      end
      OP_SUB: alu_result = alu_a - alu_b;
      OP_MUL: alu_result = prod[31:0];
      OP_DIV: alu_result = (alu_b != 0) ?
                           alu_a / alu_b : '0;
      default: alu_result = alu_a ^ alu_b;
    endcase
    alu_mul_hi = prod[63:32];
    alu_n = alu_result[31];
    alu_z = (alu_result == 0);
  end

  task automatic drive(input logic [3:0] op,
    input logic [31:0] a, input logic [31:0] b,
    input logic [3:0] tag);
    cmd_valid = 1'b1;
    cmd_op  = op;
    cmd_a   = a;
    cmd_b   = b;
    cmd_tag = tag;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid: got %b want 0",
               rsp_valid);
    end
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_ready_busy: got %b%b want 10",
               cmd_ready, busy);
    end
    checks++;
    if (fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL rst_level: got %0d want 0",
               fifo_level);
    end
    checks++;
    if (alu_op !== 4'd0 || alu_a !== 32'd0 ||
        alu_b !== 32'd0) begin
      errors++;
      $display("FAIL rst_alu: got op %0d a %0h b %0h want 0",
               alu_op, alu_a, alu_b);
    end
    checks++;
    if (rsp_result !== 32'd0 || rsp_hi !== 32'd0 ||
        rsp_tag !== 4'd0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_rsp: got %0h %0h %0h %b want 0",
               rsp_result, rsp_hi, rsp_tag, rsp_err);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // One command from an idle sequencer through its
  // handshake; lat counts edges from pop to rsp_valid.
  task automatic run_one(input string nm,
    input logic [3:0] op, input logic [31:0] a,
    input logic [31:0] b, input logic [3:0] tag,
    input int lat, input logic [31:0] er,
    input logic [31:0] eh, input logic [3:0] ef,
    input logic ee, input logic [3:0] aop,
    input logic [31:0] aa);
    int n;
    rsp_ready = 1'b1;
    drive(op, a, b, tag);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++;
    if (fifo_level !== 3'd1) begin
      errors++;
      $display("FAIL %s push_level: got %0d want 1",
               nm, fifo_level);
    end
    @(posedge clk); #1;
    checks++;
    if (alu_op !== aop || alu_a !== aa) begin
      errors++;
      $display("FAIL %s alu_after_pop: got %0d/%0h want %0d/%0h",
               nm, alu_op, alu_a, aop, aa);
    end
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== lat || rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d",
               nm, n, lat);
    end
    checks++;
    if (rsp_result !== er) begin
      errors++;
      $display("FAIL %s result: got %0h want %0h",
               nm, rsp_result, er);
    end
    checks++;
    if (rsp_hi !== eh) begin
      errors++;
      $display("FAIL %s hi: got %0h want %0h",
               nm, rsp_hi, eh);
    end
    checks++;
    if (rsp_flags !== ef) begin
      errors++;
      $display("FAIL %s flags: got %b want %b",
               nm, rsp_flags, ef);
    end
    checks++;
    if (rsp_tag !== tag || rsp_err !== ee) begin
      errors++;
      $display("FAIL %s tag_err: got %0d/%b want %0d/%b",
               nm, rsp_tag, rsp_err, tag, ee);
    end
    checks++;
    if (alu_op !== aop || alu_a !== aa) begin
      errors++;
      $display("FAIL %s alu_at_rsp: got %0d/%0h want %0d/%0h",
               nm, alu_op, alu_a, aop, aa);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s valid_after_hs: got %b want 0",
               nm, rsp_valid);
    end
  endtask

  task automatic test_add();
    run_one("add", OP_ADD, 32'd10, 32'd5, 4'd3, 1,
            32'd15, 32'd0, 4'b0000, 1'b0,
            OP_ADD, 32'd10);
    run_one("add_carry", OP_ADD, 32'hFFFF_FFFF,
            32'd1, 4'd6, 1, 32'd0, 32'd0, 4'b0101,
            1'b0, OP_ADD, 32'hFFFF_FFFF);
  endtask

  task automatic test_muldiv();
    run_one("mul", OP_MUL, 32'd10, 32'd5, 4'd1, 2,
            32'd50, 32'd0, 4'b0000, 1'b0,
            OP_MUL, 32'd10);
    run_one("mul_hi", OP_MUL, 32'h1_0000,
            32'h1_0000, 4'd4, 2, 32'd0, 32'd1,
            4'b0100, 1'b0, OP_MUL, 32'h1_0000);
    run_one("div", OP_DIV, 32'd15, 32'd4, 4'd8, 2,
            32'd3, 32'd0, 4'b0000, 1'b0,
            OP_DIV, 32'd15);
  endtask

  task automatic test_hi_gate();
    run_one("sub_hi", OP_SUB, 32'h1_0000,
            32'h1_0000, 4'd5, 1, 32'd0, 32'd0,
            4'b0100, 1'b0, OP_SUB, 32'h1_0000);
  endtask

  task automatic test_div0();
    run_one("div0", OP_DIV, 32'd15, 32'd0, 4'd7, 0,
            32'd0, 32'd0, 4'b0000, 1'b1,
            OP_SUB, 32'h1_0000);
  endtask

  task automatic test_illegal();
    int n;
    rsp_ready = 1'b1;
    drive(4'b1111, 32'd1, 32'd2, 4'd2);
    @(posedge clk); #1;
    drive(OP_SUB, 32'd10, 32'd5, 4'd9);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 ||
        rsp_tag !== 4'd2) begin
      errors++;
      $display("FAIL ill_rsp: got v%b e%b t%0d want v1 e1 t2",
               rsp_valid, rsp_err, rsp_tag);
    end
    checks++;
    if (alu_op !== OP_SUB || alu_a !== 32'h1_0000) begin
      errors++;
      $display("FAIL ill_alu: got %0d/%0h want 1/10000",
               alu_op, alu_a);
    end
    @(posedge clk); #1;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'd5 ||
        rsp_tag !== 4'd9 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL ill_next: got v%b r%0d t%0d e%b want v1 r5 t9 e0",
               rsp_valid, rsp_result, rsp_tag, rsp_err);
    end
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL ill_next_gap: got %0d want 2", n);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int  got;
    bit  hs;
    bit  pushing;
    rsp_ready = 1'b0;
    drive(OP_ADD, 32'd0, 32'd100, 4'd0);
    @(posedge clk); #1;
    for (int i = 1; i < 5; i++) begin
      drive(OP_ADD, 32'(i), 32'd100, 4'(i));
      @(posedge clk); #1;
    end
    checks++;
    if (cmd_ready !== 1'b0 || fifo_level !== 3'd4) begin
      errors++;
      $display("FAIL b2b_full: got rdy %b lvl %0d want 0/4",
               cmd_ready, fifo_level);
    end
    drive(OP_ADD, 32'd5, 32'd100, 4'd5);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (fifo_level !== 3'd4 || rsp_valid !== 1'b1 ||
          rsp_tag !== 4'd0 || rsp_result !== 32'd100) begin
        errors++;
        $display("FAIL b2b_stall%0d: got l%0d v%b t%0d r%0d want l4 v1 t0 r100",
                 i, fifo_level, rsp_valid, rsp_tag,
                 rsp_result);
      end
    end
    rsp_ready = 1'b1;
    got = 0;
    hs = 1'b0;
    for (int cyc = 0; cyc < 200 && got < 6; cyc++) begin
      if (hs) begin
        checks++;
        if (rsp_valid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_bubble: got %b want 0",
                   rsp_valid);
        end
      end
      hs = 1'b0;
      if (rsp_valid) begin
        checks++;
        if (rsp_tag !== 4'(got) ||
            rsp_result !== 32'(got + 100) ||
            rsp_err !== 1'b0) begin
          errors++;
          $display("FAIL b2b_order: got t%0d r%0d want t%0d r%0d",
                   rsp_tag, rsp_result, got, got + 100);
        end
        got++;
        hs = 1'b1;
      end
      pushing = cmd_valid && cmd_ready;
      @(posedge clk); #1;
      if (pushing) cmd_valid = 1'b0;
    end
    checks++;
    if (got !== 6 || cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count: got %0d rsp want 6",
               got);
    end
    cmd_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int stale;
    rsp_ready = 1'b1;
    drive(OP_MUL, 32'd3, 32'd4, 4'd1);
    @(posedge clk); #1;
    drive(OP_ADD, 32'd1, 32'd1, 4'd2);
    @(posedge clk); #1;
    drive(OP_ADD, 32'd2, 32'd2, 4'd3);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++;
    if (fifo_level !== 3'd2 || alu_op !== OP_MUL ||
        rsp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: got l%0d op%0d v%b b%b want l2 op2 v0 b1",
               fifo_level, alu_op, rsp_valid, busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || fifo_level !== 3'd0 ||
        alu_op !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_async: got v%b l%0d op%0d b%b want 0/0/0/0",
               rsp_valid, fifo_level, alu_op, busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0 || busy !== 1'b0)
        stale++;
    end
    checks++;
    if (stale !== 0) begin
      errors++;
      $display("FAIL mid_stale: got %0d active cycles want 0",
               stale);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add();
    test_muldiv();
    test_hi_gate();
    test_div0();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
